// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the free-running reference clock: PLL reset, lock wait with retries, stability qualification, system reset release.
// Latency: all outputs registered; a pll_locked change reaches the FSM SYNC_STAGES edges after sampling. No backpressure.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       fail_o,
    output logic       lock_lost_o,
    output logic [7:0] retry_count_o,
    output logic [7:0] lock_loss_count_o,
    output logic [2:0] state_o
);
    localparam int CNT_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX = (CNT_A > LOCK_TIMEOUT_CYCLES) ? CNT_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       MAX_R       = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [7:0]             retry_q, retry_d;
    logic [7:0]             llc_q, llc_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   fail_q, fail_d;
    logic                   lost_q, lost_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q   <= ST_PLL_RESET;
            cnt_q     <= '0;
            sync_q    <= '0;
            retry_q   <= '0;
            llc_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            fail_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
            retry_q   <= retry_d;
            llc_q     <= llc_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            fail_q    <= fail_d;
            lost_q    <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q == MAX_R) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_PLL_RESET;
                    end
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) state_d = ST_PLL_RESET;
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_PLL_RESET;
        endcase

        if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;

        // Counter restarts on every state change and idles where no limit applies.
        if (state_d != state_q || state_d == ST_RUN || state_d == ST_FAIL) cnt_d = '0;
        else cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so the registers line up with state_q.
    always_comb begin
        pll_rst_d = (state_d == ST_PLL_RESET) || (state_d == ST_FAIL);
        sys_rst_d = (state_d != ST_RUN);
        fail_d    = (state_d == ST_FAIL);
        lost_d    = (state_q == ST_RUN) && !locked_s;
        llc_d     = llc_q;
        if (lost_d && llc_q != 8'hFF) llc_d = llc_q + 8'd1;
    end

    assign pll_rst_o         = pll_rst_q;
    assign sys_rst_o         = sys_rst_q;
    assign fail_o            = fail_q;
    assign lock_lost_o       = lost_q;
    assign retry_count_o     = retry_q;
    assign lock_loss_count_o = llc_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: constant-expectation vector table, lock-loss saturation sequence,
// and randomized pll_locked/rst stimulus compared every cycle against a behavioural model.
module tb_pll_lock_supervisor;
    localparam int P_SYNC = 2;
    localparam int P_RST  = 4;
    localparam int P_STAB = 8;
    localparam int P_TO   = 20;
    localparam int P_MAXR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_rst_o, sys_rst_o, fail_o, lock_lost_o;
    logic [7:0] retry_count_o, lock_loss_count_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES        (P_SYNC),
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_STABLE_CYCLES (P_STAB),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .MAX_RETRIES        (P_MAXR)
    ) dut (
        .refclk_i         (clk),
        .rst_i            (rst),
        .pll_locked_i     (locked),
        .pll_rst_o        (pll_rst_o),
        .sys_rst_o        (sys_rst_o),
        .fail_o           (fail_o),
        .lock_lost_o      (lock_lost_o),
        .retry_count_o    (retry_count_o),
        .lock_loss_count_o(lock_loss_count_o),
        .state_o          (state_o)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase number, time spent in phase, and a delay line of locked samples.
    int m_state, m_cnt, m_retry, m_llc;
    bit m_lost;
    bit m_sync[$];

    task automatic model_edge(input bit r, input bit l);
        bit ls;
        int nxt;
        if (r) begin
            m_state = 0; m_cnt = 0; m_retry = 0; m_llc = 0; m_lost = 0;
            m_sync = {};
            for (int i = 0; i < P_SYNC; i++) m_sync.push_back(1'b0);
        end else begin
            ls = m_sync.pop_front();
            m_sync.push_back(l);
            m_lost = 0;
            nxt = m_state;
            case (m_state)
                0: if (m_cnt >= P_RST - 1) nxt = 1;
                1: begin
                    if (ls) nxt = 2;
                    else if (m_cnt >= P_TO - 1) begin
                        if (m_retry >= P_MAXR) nxt = 4;
                        else begin m_retry++; nxt = 0; end
                    end
                end
                2: begin
                    if (!ls) nxt = 1;
                    else if (m_cnt >= P_STAB - 1) begin nxt = 3; m_retry = 0; end
                end
                3: if (!ls) begin nxt = 0; m_lost = 1; if (m_llc < 255) m_llc++; end
                default: nxt = 4;
            endcase
            m_cnt = (nxt == m_state) ? m_cnt + 1 : 0;
            m_state = nxt;
        end
    endtask

    function automatic logic [22:0] pack_act();
        return {state_o, pll_rst_o, sys_rst_o, fail_o, lock_lost_o, retry_count_o, lock_loss_count_o};
    endfunction

    task automatic show(input string name, input logic [22:0] a, input logic [22:0] e);
        $display("FAIL %s t=%0t got st=%0d prst=%0b srst=%0b fail=%0b lost=%0b rc=%0d llc=%0d | want st=%0d prst=%0b srst=%0b fail=%0b lost=%0b rc=%0d llc=%0d",
                 name, $time, a[22:20], a[19], a[18], a[17], a[16], a[15:8], a[7:0],
                 e[22:20], e[19], e[18], e[17], e[16], e[15:8], e[7:0]);
    endtask

    task automatic check_model();
        logic [22:0] e, a;
        e = {3'(m_state), (m_state == 0 || m_state == 4), (m_state != 3), (m_state == 4),
             m_lost, 8'(m_retry), 8'(m_llc)};
        a = pack_act();
        checks++;
        if (a !== e) begin
            errors++;
            show("model", a, e);
        end
    endtask

    task automatic step(input bit r, input bit l);
        rst = r;
        locked = l;
        @(posedge clk);
        model_edge(r, l);
        #1;
        check_model();
    endtask

    typedef struct {
        bit r; bit l; int n;
        int st; bit prst; bit srst; bit fl; bit lost; int rc; int llc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit l, input int n, input int st, input bit prst,
                       input bit srst, input bit fl, input bit lost, input int rc, input int llc);
        vec_t v;
        v.r = r; v.l = l; v.n = n; v.st = st; v.prst = prst; v.srst = srst;
        v.fl = fl; v.lost = lost; v.rc = rc; v.llc = llc;
        tbl.push_back(v);
    endtask

    initial begin
        logic [22:0] e, a;
        int guard;
        int hold;
        bit lv;
        rst = 1'b1;
        locked = 1'b0;

        //  r  l   n  st prst srst fail lost rc llc
        add(1, 0,  2, 0, 1, 1, 0, 0, 0, 0);  // reset state
        add(0, 0,  3, 0, 1, 1, 0, 0, 0, 0);  // pll_rst high 4 cycles
        add(0, 0,  1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0,  9, 1, 0, 1, 0, 0, 0, 0);
        add(0, 1,  2, 1, 0, 1, 0, 0, 0, 0);  // sync delay
        add(0, 1,  1, 2, 0, 1, 0, 0, 0, 0);
        add(0, 1,  7, 2, 0, 1, 0, 0, 0, 0);
        add(0, 1,  1, 3, 0, 0, 0, 0, 0, 0);  // release after 8 stable cycles
        add(0, 1,  3, 3, 0, 0, 0, 0, 0, 0);
        add(0, 0,  2, 3, 0, 0, 0, 0, 0, 0);  // drop not yet through synchronizer
        add(0, 0,  1, 0, 1, 1, 0, 1, 0, 1);  // lock_lost pulse
        add(0, 0,  1, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0,  2, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0,  1, 1, 0, 1, 0, 0, 0, 1);
        add(0, 1,  2, 1, 0, 1, 0, 0, 0, 1);
        add(0, 1,  1, 2, 0, 1, 0, 0, 0, 1);
        add(0, 1,  3, 2, 0, 1, 0, 0, 0, 1);
        add(0, 0,  2, 2, 0, 1, 0, 0, 0, 1);  // 3-cycle glitch in STABILIZE
        add(0, 0,  1, 1, 0, 1, 0, 0, 0, 1);
        add(0, 1,  2, 1, 0, 1, 0, 0, 0, 1);
        add(0, 1,  1, 2, 0, 1, 0, 0, 0, 1);
        add(0, 1,  7, 2, 0, 1, 0, 0, 0, 1);  // full requalification
        add(0, 1,  1, 3, 0, 0, 0, 0, 0, 1);
        add(0, 0,  2, 3, 0, 0, 0, 0, 0, 1);
        add(0, 0,  1, 0, 1, 1, 0, 1, 0, 2);
        add(0, 0,  4, 1, 0, 1, 0, 0, 0, 2);
        add(0, 0, 19, 1, 0, 1, 0, 0, 0, 2);
        add(0, 0,  1, 0, 1, 1, 0, 0, 1, 2);  // first timeout
        add(0, 0,  4, 1, 0, 1, 0, 0, 1, 2);
        add(0, 0, 20, 0, 1, 1, 0, 0, 2, 2);
        add(0, 0,  4, 1, 0, 1, 0, 0, 2, 2);
        add(0, 0, 20, 4, 1, 1, 1, 0, 2, 2);  // retries exhausted
        add(0, 0, 30, 4, 1, 1, 1, 0, 2, 2);
        add(0, 1, 10, 4, 1, 1, 1, 0, 2, 2);  // terminal even with lock
        add(1, 1,  1, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1,  3, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1,  1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 1,  1, 2, 0, 1, 0, 0, 0, 0);
        add(0, 1,  8, 3, 0, 0, 0, 0, 0, 0);
        add(0, 0,  3, 0, 1, 1, 0, 1, 0, 1);
        add(0, 1,  4, 1, 0, 1, 0, 0, 0, 1);
        add(0, 1,  1, 2, 0, 1, 0, 0, 0, 1);
        add(0, 1,  8, 3, 0, 0, 0, 0, 0, 1);
        add(1, 1,  1, 0, 1, 1, 0, 0, 0, 0);  // rst during RUN
        add(0, 1,  5, 2, 0, 1, 0, 0, 0, 0);
        add(0, 1,  2, 2, 0, 1, 0, 0, 0, 0);
        add(1, 1,  1, 0, 1, 1, 0, 0, 0, 0);  // rst during STABILIZE
        add(0, 0,  4, 1, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            repeat (tbl[i].n) step(tbl[i].r, tbl[i].l);
            e = {3'(tbl[i].st), tbl[i].prst, tbl[i].srst, tbl[i].fl, tbl[i].lost,
                 8'(tbl[i].rc), 8'(tbl[i].llc)};
            a = pack_act();
            checks++;
            if (a !== e) begin
                errors++;
                show($sformatf("vec%0d", i), a, e);
            end
        end

        // Saturation: 260 lock-loss events.
        step(1'b1, 1'b0);
        for (int k = 0; k < 260; k++) begin
            guard = 0;
            while (state_o != 3'd3 && guard < 100) begin step(1'b0, 1'b1); guard++; end
            guard = 0;
            step(1'b0, 1'b0);
            while (!lock_lost_o && guard < 10) begin step(1'b0, 1'b0); guard++; end
            if (!lock_lost_o) begin
                checks++;
                errors++;
                $display("FAIL sat_timeout event=%0d got lock_lost=%0b want 1", k, lock_lost_o);
                break;
            end
        end
        checks++;
        if (lock_loss_count_o !== 8'd255) begin
            errors++;
            $display("FAIL sat_count got %0d want 255", lock_loss_count_o);
        end

        // Randomized stimulus against the model.
        step(1'b1, 1'b0);
        hold = 0;
        lv = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                lv = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            step(($urandom_range(0, 199) == 0), lv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
